// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
package riscv_ctrl_pkg;

  // Main FSM states.
  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBeq,
    StJal
  } state_e;

  // Supported opcodes.
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRtype = 7'b0110011;
  localparam logic [6:0] OpItype = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  // ALUOp codes handed from the main FSM to the ALU decoder.
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // ALUControl codes.
  localparam logic [2:0] AluCtrlAdd = 3'b000;
  localparam logic [2:0] AluCtrlSub = 3'b001;
  localparam logic [2:0] AluCtrlAnd = 3'b010;
  localparam logic [2:0] AluCtrlOr  = 3'b011;
  localparam logic [2:0] AluCtrlSlt = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus instruction fields to an ALU operation code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  // Pure combinational decode; anything unlisted falls back to add.
  always_comb begin
    alu_control_o = AluCtrlAdd;
    unique case (alu_op_i)
      AluOpAdd: alu_control_o = AluCtrlAdd;
      AluOpSub: alu_control_o = AluCtrlSub;
      AluOpFunct: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? AluCtrlSub : AluCtrlAdd;
          3'b010:  alu_control_o = AluCtrlSlt;
          3'b110:  alu_control_o = AluCtrlOr;
          3'b111:  alu_control_o = AluCtrlAnd;
          default: alu_control_o = AluCtrlAdd;
        endcase
      end
      default: alu_control_o = AluCtrlAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM, immediate-format select and output gating for the multicycle datapath.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 illegal_instr
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update, branch, ir_write, reg_write, mem_write, illegal;

  // State register; reset drops straight back to FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StFetch;
    else          state_q <= state_d;
  end

  // Next-state and Moore outputs, defaults first.
  always_comb begin
    state_d   = StFetch;
    alu_op    = AluOpAdd;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      StFetch: begin
        state_d   = StDecode;
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecuteR;
          OpItype:         state_d = StExecuteI;
          OpBeq:           state_d = StBeq;
          OpJal:           state_d = StJal;
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        state_d = (op == OpLoad) ? StMemRead : StMemWrite;
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: begin
        state_d = StMemWb;
        AdrSrc  = 1'b1;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      StMemWrite: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      StExecuteR: begin
        state_d = StAluWb;
        ALUSrcA = 2'b10;
        alu_op  = AluOpFunct;
      end
      StExecuteI: begin
        state_d = StAluWb;
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = AluOpFunct;
      end
      StAluWb: reg_write = 1'b1;
      StBeq: begin
        ALUSrcA = 2'b10;
        alu_op  = AluOpSub;
        branch  = 1'b1;
      end
      StJal: begin
        state_d   = StAluWb;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  // Immediate format depends only on the opcode.
  always_comb begin
    case (op)
      OpStore: ImmSrc = 2'b01;
      OpBeq:   ImmSrc = 2'b10;
      OpJal:   ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Enables are masked by reset so FETCH's enables stay quiet while held in reset.
  always_comb begin
    PCWrite       = reset_n & (pc_update | (branch & zero));
    IRWrite       = reset_n & ir_write;
    RegWrite      = reset_n & reg_write;
    MemWrite      = reset_n & mem_write;
    illegal_instr = reset_n & illegal;
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class state by state.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int checks   = 0;
  int failures = 0;

  multicycle_controller #(.ALUCTRL_W(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op           (op),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .zero         (zero),
    .PCWrite      (PCWrite),
    .AdrSrc       (AdrSrc),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .RegWrite     (RegWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ImmSrc       (ImmSrc),
    .ALUControl   (ALUControl),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  // Packed view: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,
  // ALUControl,illegal_instr}
  function automatic logic [16:0] obs();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
            ALUControl, illegal_instr};
  endfunction

  function automatic logic [16:0] ev(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] imm, input logic [2:0] alu,
                                     input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
  endfunction

  task automatic drive(input logic [31:0] instr);
    op       = instr[6:0];
    funct3   = instr[14:12];
    funct7b5 = instr[30];
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [16:0] exp_v;
    reset_n = 1'b0;
    zero    = 1'b0;
    drive(32'h002081B3);
    #12;
    exp_v = ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    checks++;
    if (obs() !== exp_v) begin
      failures++;
      $display("FAIL reset_hold got=%h want=%h", obs(), exp_v);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    exp_v = ev(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    checks++;
    if (obs() !== exp_v) begin
      failures++;
      $display("FAIL reset_release_fetch got=%h want=%h", obs(), exp_v);
    end
  endtask

  // R/I-type: FETCH, DECODE, EXECUTE, ALUWB, back to FETCH after 4 cycles.
  // zero is toggled every cycle to show it has no effect outside BEQ.
  task automatic test_alu(input string name, input logic [31:0] instr, input logic [1:0] ex_sb,
                          input logic [2:0] ex_alu);
    logic [16:0] exp_v [5];
    exp_v[0] = ev(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    exp_v[1] = ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0);
    exp_v[2] = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, ex_sb, 2'b00, ex_alu, 0);
    exp_v[3] = ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    exp_v[4] = exp_v[0];
    drive(instr);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      zero = ~zero;
      #1;
      checks++;
      if (obs() !== exp_v[i]) begin
        failures++;
        $display("FAIL %s cycle%0d got=%h want=%h", name, i, obs(), exp_v[i]);
      end
    end
  endtask

  task automatic test_lw();
    logic [16:0] exp_v [6];
    exp_v[0] = ev(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    exp_v[1] = ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0);
    exp_v[2] = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
    exp_v[3] = ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    exp_v[4] = ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    exp_v[5] = exp_v[0];
    drive(32'h0020A183);
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++;
      if (obs() !== exp_v[i]) begin
        failures++;
        $display("FAIL lw cycle%0d got=%h want=%h", i, obs(), exp_v[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [16:0] exp_v [5];
    int mw_cycles = 0;
    exp_v[0] = ev(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    exp_v[1] = ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0);
    exp_v[2] = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0);
    exp_v[3] = ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);
    exp_v[4] = exp_v[0];
    drive(32'h0030A123);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      if (MemWrite === 1'b1) mw_cycles++;
      checks++;
      if (obs() !== exp_v[i]) begin
        failures++;
        $display("FAIL sw cycle%0d got=%h want=%h", i, obs(), exp_v[i]);
      end
    end
    checks++;
    if (mw_cycles != 1) begin
      failures++;
      $display("FAIL sw_memwrite_cycles got=%0d want=1", mw_cycles);
    end
  endtask

  task automatic test_beq(input logic z);
    logic [16:0] exp_v [4];
    exp_v[0] = ev(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0);
    exp_v[1] = ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0);
    exp_v[2] = ev(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0);
    exp_v[3] = exp_v[0];
    drive(32'h00208463);
    zero = z;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      checks++;
      if (obs() !== exp_v[i]) begin
        failures++;
        $display("FAIL beq_zero%0d cycle%0d got=%h want=%h", z, i, obs(), exp_v[i]);
      end
    end
  endtask

  task automatic test_jal();
    logic [16:0] exp_v [5];
    exp_v[0] = ev(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 0);
    exp_v[1] = ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000, 0);
    exp_v[2] = ev(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0);
    exp_v[3] = ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 0);
    exp_v[4] = exp_v[0];
    drive(32'h008000EF);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++;
      if (obs() !== exp_v[i]) begin
        failures++;
        $display("FAIL jal cycle%0d got=%h want=%h", i, obs(), exp_v[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [16:0] exp_v [4];
    exp_v[0] = ev(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    exp_v[1] = ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1);
    exp_v[2] = exp_v[0];
    exp_v[3] = exp_v[1];
    drive(32'h0000007F);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      checks++;
      if (obs() !== exp_v[i]) begin
        failures++;
        $display("FAIL illegal cycle%0d got=%h want=%h", i, obs(), exp_v[i]);
      end
    end
    // Leave the FSM in FETCH for the next test.
    step();
  endtask

  task automatic test_reset_mid_instr();
    logic [16:0] exp_v;
    drive(32'h0030A123);
    #1;
    step();
    step();
    step();
    checks++;
    if (MemWrite !== 1'b1) begin
      failures++;
      $display("FAIL midreset_memwrite_before got=%b want=1", MemWrite);
    end
    reset_n = 1'b0;
    #1;
    exp_v = ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    checks++;
    if (obs() !== exp_v) begin
      failures++;
      $display("FAIL midreset_hold got=%h want=%h", obs(), exp_v);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    exp_v = ev(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    checks++;
    if (obs() !== exp_v) begin
      failures++;
      $display("FAIL midreset_fetch got=%h want=%h", obs(), exp_v);
    end
    step();
    exp_v = ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0);
    checks++;
    if (obs() !== exp_v) begin
      failures++;
      $display("FAIL midreset_decode got=%h want=%h", obs(), exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_alu("add", 32'h002081B3, 2'b00, 3'b000);
    test_alu("sub", 32'h402081B3, 2'b00, 3'b001);
    test_alu("addi", 32'h40208193, 2'b01, 3'b000);
    test_alu("or", 32'h0020E1B3, 2'b00, 3'b011);
    test_alu("slti", 32'h0020A193, 2'b01, 3'b101);
    test_alu("and", 32'h0020F1B3, 2'b00, 3'b010);
    test_lw();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal();
    test_illegal();
    test_reset_mid_instr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
